// File: rtl/sysarr_row_serializer_if.sv
// Row/element handshake bundle for sysarr_row_serializer: a parallel row goes in,
// one element per shift comes out. master = serializer side, slave = environment side.
interface sysarr_row_serializer_if #(
   parameter int DW = 16,
   parameter int N  = 4
);
   logic [DW*N-1:0] row_in;
   logic            row_valid;
   logic            row_ready;
   logic            shift;
   logic [DW-1:0]   shift_value;
   logic            shift_last;
   logic            shift_stall;
   logic            busy;

   modport master (
      input  row_in,
      input  row_valid,
      input  shift_stall,
      output row_ready,
      output shift,
      output shift_value,
      output shift_last,
      output busy
   );

   modport slave (
      output row_in,
      output row_valid,
      output shift_stall,
      input  row_ready,
      input  shift,
      input  shift_value,
      input  shift_last,
      input  busy
   );
endinterface

// File: rtl/sysarr_row_serializer.sv
// Parallel-row to element-stream serializer, element N-1 first, element 0 last.
// Optional double buffering (zero-bubble back-to-back rows) via SYSARR_SER_DOUBLE_BUF_EN.
module sysarr_row_serializer #(
   parameter int DW = 16,
   parameter int N  = 4
) (
   input  logic                   clk,
   input  logic                   nRST,
   sysarr_row_serializer_if.master bus
);
   localparam int             IW      = (N > 1) ? $clog2(N) : 1;
   localparam logic [IW-1:0]  IDX_TOP = IW'(N - 1);
   localparam logic [IW-1:0]  IDX_ONE = IW'(1);
   localparam logic [IW-1:0]  IDX_ZERO = IW'(0);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      DRAIN = 1'b1
   } state_t;

   typedef logic [N-1:0][DW-1:0] row_t;

   state_t        state_r;
   state_t        state_nxt_s;
   logic [IW-1:0] idx_r;
   logic [IW-1:0] idx_nxt_s;
   row_t          active_r;
   row_t          active_nxt_s;
   logic          pending_full_s;

   logic          ready_s;
   logic          accept_s;
   logic          shift_s;
   logic          last_s;
   logic          busy_s;
   logic [DW-1:0] value_s;

`ifdef SYSARR_SER_DOUBLE_BUF_EN
   row_t          pending_r;
   row_t          pending_nxt_s;
   logic          pending_full_r;
   logic          pending_full_nxt_s;

   assign pending_full_s = pending_full_r;
`else
   assign pending_full_s = 1'b0;
`endif

   // Handshake and element-stream outputs derived from the current state.
   always_comb begin
      shift_s = (state_r == DRAIN) && !bus.shift_stall;
      last_s  = shift_s && (idx_r == IDX_ZERO);
      busy_s  = (state_r == DRAIN) || pending_full_s;
      if (state_r == DRAIN) begin
         value_s = active_r[idx_r];
      end else begin
         value_s = {DW{1'b0}};
      end
`ifdef SYSARR_SER_DOUBLE_BUF_EN
      ready_s = !pending_full_s;
`else
      ready_s = (state_r == IDLE);
`endif
      accept_s = bus.row_valid && ready_s;
   end

   assign bus.row_ready   = ready_s;
   assign bus.shift       = shift_s;
   assign bus.shift_value = value_s;
   assign bus.shift_last  = last_s;
   assign bus.busy        = busy_s;

   // Next-state, index and row-buffer update.
   always_comb begin
      state_nxt_s  = state_r;
      idx_nxt_s    = idx_r;
      active_nxt_s = active_r;
`ifdef SYSARR_SER_DOUBLE_BUF_EN
      pending_nxt_s      = pending_r;
      pending_full_nxt_s = pending_full_r;
`endif
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               state_nxt_s  = DRAIN;
               active_nxt_s = bus.row_in;
               idx_nxt_s    = IDX_TOP;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         DRAIN: begin
            if (last_s) begin
`ifdef SYSARR_SER_DOUBLE_BUF_EN
               // Pending row takes priority; a fresh row can only arrive when none is pending.
               if (pending_full_r) begin
                  active_nxt_s       = pending_r;
                  idx_nxt_s          = IDX_TOP;
                  pending_full_nxt_s = 1'b0;
               end else if (accept_s) begin
                  active_nxt_s = bus.row_in;
                  idx_nxt_s    = IDX_TOP;
               end else begin
                  state_nxt_s = IDLE;
               end
`else
               state_nxt_s = IDLE;
`endif
            end else begin
               if (shift_s) begin
                  idx_nxt_s = idx_r - IDX_ONE;
               end else begin
                  idx_nxt_s = idx_r;
               end
`ifdef SYSARR_SER_DOUBLE_BUF_EN
               if (accept_s) begin
                  pending_nxt_s      = bus.row_in;
                  pending_full_nxt_s = 1'b1;
               end else begin
                  pending_full_nxt_s = pending_full_r;
               end
`endif
            end
         end
         default: begin
            state_nxt_s  = IDLE;
            idx_nxt_s    = IDX_ZERO;
            active_nxt_s = '0;
         end
      endcase
   end

   // State, index and active-row registers.
   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         state_r  <= IDLE;
         idx_r    <= IDX_ZERO;
         active_r <= '0;
      end else begin
         state_r  <= state_nxt_s;
         idx_r    <= idx_nxt_s;
         active_r <= active_nxt_s;
      end
   end

`ifdef SYSARR_SER_DOUBLE_BUF_EN
   // Pending-row register for the second buffer slot.
   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         pending_r      <= '0;
         pending_full_r <= 1'b0;
      end else begin
         pending_r      <= pending_nxt_s;
         pending_full_r <= pending_full_nxt_s;
      end
   end
`endif

endmodule

// File: tb/tb_sysarr_row_serializer.sv
// Randomized bench for sysarr_row_serializer against a row-queue reference model,
// plus a shift-in register that must rebuild each accepted row.
module tb_sysarr_row_serializer;
   localparam int DW = 16;
   localparam int N  = 4;
   localparam int RW = DW * N;

   logic clk  = 1'b0;
   logic nRST = 1'b0;

   always #5 clk = ~clk;

   sysarr_row_serializer_if #(.DW(DW), .N(N)) bus ();

   sysarr_row_serializer #(.DW(DW), .N(N)) dut (
      .clk  (clk),
      .nRST (nRST),
      .bus  (bus)
   );

   int n_cmp = 0;
   int n_err = 0;

   // Model: held rows (front is draining, second is pending) and elements left in the front row.
   logic [RW-1:0] rows_q[$];
   int            rem = 0;
   logic [RW-1:0] rt_q[$];
   logic [RW-1:0] rt_sr = '0;
   logic [DW-1:0] em_q[$];
   logic          saw_shift;
   logic          saw_accept;

   task automatic check_eq(input string tag, input logic [RW-1:0] act, input logic [RW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] elem(input logic [RW-1:0] r, input int k);
      return r[k*DW +: DW];
   endfunction

   function automatic logic model_ready();
`ifdef SYSARR_SER_DOUBLE_BUF_EN
      return rows_q.size() < 2;
`else
      return rem == 0;
`endif
   endfunction

   task automatic model_reset();
      rows_q.delete();
      rt_q.delete();
      rem   = 0;
      rt_sr = '0;
   endtask

   task automatic step();
      logic          e_ready;
      logic          e_shift;
      logic          e_last;
      logic [DW-1:0] e_val;
      @(negedge clk);
      e_ready = model_ready();
      e_shift = (rem > 0) && !bus.shift_stall;
      e_last  = e_shift && (rem == 1);
      if (rem > 0) e_val = elem(rows_q[0], rem - 1);
      else         e_val = '0;
      check_eq("row_ready",   RW'(bus.row_ready),   RW'(e_ready));
      check_eq("shift",       RW'(bus.shift),       RW'(e_shift));
      check_eq("shift_value", RW'(bus.shift_value), RW'(e_val));
      check_eq("shift_last",  RW'(bus.shift_last),  RW'(e_last));
      check_eq("busy",        RW'(bus.busy),        RW'(rows_q.size() > 0));
      saw_shift  = bus.shift;
      saw_accept = bus.row_valid && e_ready;
      if (bus.shift) begin
         em_q.push_back(bus.shift_value);
         rt_sr = {rt_sr[RW-DW-1:0], bus.shift_value};
      end
      if (bus.shift_last) begin
         if (rt_q.size() == 0) check_eq("roundtrip_orphan", RW'(rt_q.size()), RW'(1));
         else                  check_eq("roundtrip", rt_sr, rt_q.pop_front());
      end
      @(posedge clk);
      if (e_shift) begin
         rem--;
         if (rem == 0) begin
            rows_q.delete(0);
            if (rows_q.size() > 0) rem = N;
         end
      end
      if (saw_accept) begin
         rows_q.push_back(bus.row_in);
         rt_q.push_back(bus.row_in);
         if (rem == 0) rem = N;
      end
      #1;
   endtask

   task automatic send_row(input logic [RW-1:0] row);
      int budget = 10;
      bus.row_valid = 1'b1;
      bus.row_in    = row;
      saw_accept    = 1'b0;
      while (!saw_accept && budget > 0) begin
         step();
         budget--;
      end
      check_eq("accept_in_time", RW'(saw_accept), RW'(1));
      bus.row_valid = 1'b0;
      bus.row_in    = {$urandom, $urandom};
   endtask

   task automatic check_emissions(input string tag, input logic [DW-1:0] exp[$]);
      check_eq({tag, "_count"}, RW'(em_q.size()), RW'(exp.size()));
      for (int i = 0; i < exp.size() && i < em_q.size(); i++) begin
         check_eq(tag, RW'(em_q[i]), RW'(exp[i]));
      end
   endtask

   initial begin
      int accepted;
      int shifts;
      int gaps;
      int budget;
      logic [DW-1:0] exp_q[$];

      bus.row_in      = '0;
      bus.row_valid   = 1'b0;
      bus.shift_stall = 1'b0;

      // Reset then idle
      #12;
      check_eq("rst_ready", RW'(bus.row_ready),   RW'(1));
      check_eq("rst_shift", RW'(bus.shift),       RW'(0));
      check_eq("rst_value", RW'(bus.shift_value), RW'(0));
      check_eq("rst_last",  RW'(bus.shift_last),  RW'(0));
      check_eq("rst_busy",  RW'(bus.busy),        RW'(0));
      model_reset();
      @(posedge clk);
      #1;
      nRST = 1'b1;
      repeat (2) step();

      // Single row
      em_q.delete();
      send_row(64'h0004_0003_0002_0001);
      repeat (6) step();
      exp_q = '{16'd4, 16'd3, 16'd2, 16'd1};
      check_emissions("single_row", exp_q);

      // Stall after the first element
      em_q.delete();
      send_row(64'h0004_0003_0002_0001);
      step();
      bus.shift_stall = 1'b1;
      repeat (3) step();
      bus.shift_stall = 1'b0;
      repeat (5) step();
      check_emissions("stall_row", exp_q);

      // Back-to-back rows with row_valid held high
      em_q.delete();
      accepted = 0;
      shifts   = 0;
      gaps     = 0;
      budget   = 30;
      bus.row_valid = 1'b1;
      bus.row_in    = 64'h0001_0002_0003_0004;
      while (shifts < 8 && budget > 0) begin
         step();
         budget--;
         if (saw_shift) shifts++;
         else if (shifts > 0) gaps++;
         if (saw_accept) begin
            accepted++;
            bus.row_in = 64'h0005_0006_0007_0008;
            if (accepted == 2) bus.row_valid = 1'b0;
         end
      end
      bus.row_valid = 1'b0;
      check_eq("b2b_shifts", RW'(shifts), RW'(8));
`ifdef SYSARR_SER_DOUBLE_BUF_EN
      check_eq("b2b_gaps", RW'(gaps), RW'(0));
`else
      check_eq("b2b_gaps", RW'(gaps), RW'(1));
`endif
      exp_q = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
      check_emissions("b2b_values", exp_q);
      repeat (3) step();

      // Reset mid-drain after two elements
      send_row({$urandom, $urandom});
      repeat (2) step();
      nRST = 1'b0;
      #1;
      check_eq("mid_rst_ready", RW'(bus.row_ready),   RW'(1));
      check_eq("mid_rst_shift", RW'(bus.shift),       RW'(0));
      check_eq("mid_rst_value", RW'(bus.shift_value), RW'(0));
      check_eq("mid_rst_last",  RW'(bus.shift_last),  RW'(0));
      check_eq("mid_rst_busy",  RW'(bus.busy),        RW'(0));
      model_reset();
      @(posedge clk);
      #1;
      nRST = 1'b1;
      em_q.delete();
      repeat (6) step();
      check_eq("mid_rst_no_emit", RW'(em_q.size()), RW'(0));

      // Random traffic
      for (int i = 0; i < 800; i++) begin
         bus.shift_stall = ($urandom_range(0, 3) == 0);
         bus.row_valid   = ($urandom_range(0, 1) == 1);
         bus.row_in      = {$urandom, $urandom};
         step();
      end
      bus.row_valid   = 1'b0;
      bus.shift_stall = 1'b0;
      repeat (12) step();
      check_eq("final_rows_outstanding", RW'(rt_q.size()), RW'(0));
      check_eq("final_busy", RW'(bus.busy), RW'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/sysarr_row_serializer.md
SYSARR_ROW_SERIALIZER -- requirements
Module: sysarr_row_serializer

Interface
REQ-001 The parameter DW SHALL default to 16 and set the element width in bits.
REQ-002 The parameter N SHALL default to 4 and set the number of elements per row.
REQ-003 The port clk SHALL be an input, 1 bit wide, and be the single clock; all state updates on its rising edge.
REQ-004 The port nRST SHALL be an input, 1 bit wide, and be the reset: asynchronous, active-low.
REQ-005 The port row_in SHALL be an input, DW*N bits wide, carrying the parallel row; element k occupies bits [(k+1)*DW-1 : k*DW].
REQ-006 The port row_valid SHALL be an input, 1 bit wide, asserted by the producer when row_in holds a row.
REQ-007 The port row_ready SHALL be an output, 1 bit wide, asserted when the block accepts a row this cycle.
REQ-008 The port shift SHALL be an output, 1 bit wide, and be the per-element strobe: shift_value is transferred this cycle.
REQ-009 The port shift_value SHALL be an output, DW bits wide, carrying the element presented downstream.
REQ-010 The port shift_last SHALL be an output, 1 bit wide, asserted with shift on the final element of a row.
REQ-011 The port shift_stall SHALL be an input, 1 bit wide; while it is high the downstream cannot take an element.
REQ-012 The port busy SHALL be an output, 1 bit wide, high whenever any row is held (draining or pending).

Function
REQ-013 A row SHALL be accepted on a rising edge where row_valid && row_ready; row_in is captured into the active row register, or into the pending register when the active register is occupied.
REQ-014 The FSM SHALL have exactly two states, IDLE and DRAIN; IDLE->DRAIN on acceptance; DRAIN->IDLE after the last element when no row is pending.
REQ-015 The element index counter SHALL be loaded with N-1 on row load and decrement by 1 on each edge where shift is high.
REQ-016 Emission order SHALL be element N-1 first, down to element 0 last, so a downstream shift-in register (newest in low slot) reconstructs row_in bit-exactly after N shifts.
REQ-017 shift SHALL equal (state==DRAIN) && !shift_stall, combinationally.
REQ-018 shift_value SHALL equal active element [index] whenever state==DRAIN, stalled or not, and SHALL be 0 in IDLE.
REQ-019 shift_last SHALL equal shift && (index==0).
REQ-020 Latency SHALL be one cycle: a row accepted at edge t produces its first shift in the cycle following t (absent stall).
REQ-021 While shift_stall is high, index, active row and shift_value SHALL hold unchanged; there is no timeout.
REQ-022 row_valid asserted while row_ready is low SHALL have no effect; row_in need not be held stable.
REQ-023 A row of N elements SHALL take exactly N unstalled shift cycles; index SHALL never wrap below 0.
REQ-024 busy SHALL equal (state==DRAIN) || pending_full.

Reset
REQ-025 Asserting nRST low SHALL immediately force: state IDLE, index 0, active and pending registers 0, pending_full 0.
REQ-026 During and after reset, outputs SHALL be: row_ready 1, shift 0, shift_value 0, shift_last 0, busy 0.
REQ-027 Reset mid-drain SHALL discard the partial row and any pending row; no further elements of them are emitted.

Configuration
REQ-028 Macro SYSARR_SER_DOUBLE_BUF_EN SHALL select double buffering.
REQ-029 With SYSARR_SER_DOUBLE_BUF_EN defined: the pending register exists; row_ready = !pending_full.
REQ-030 With SYSARR_SER_DOUBLE_BUF_EN defined: on a shift_last edge with pending_full, the pending register moves to active, the index reloads to N-1, and the state stays DRAIN (zero bubble).
REQ-031 With SYSARR_SER_DOUBLE_BUF_EN defined: a row accepted on the same edge as shift_last with no pending row loads directly into active.
REQ-032 Without SYSARR_SER_DOUBLE_BUF_EN: there is no pending register (pending_full tied 0); row_ready = (state==IDLE), giving one idle cycle between consecutive rows.

Verification (DW=16, N=4)
REQ-033 Reset then idle: nRST low -> row_ready=1, shift=0, shift_value=0, busy=0.
REQ-034 Single row: row_in=0x0004_0003_0002_0001 accepted -> next 4 cycles emit shift_value 4,3,2,1, with shift_last high only on 1; then IDLE.
REQ-035 Stall: shift_stall high for 3 cycles after the first element -> value 3 is held for 3 cycles with shift=0, then sequence 3,2,1 resumes; total emissions = 4.
REQ-036 Back-to-back, rows A=0x...1/2/3/4 and B=0x...5/6/7/8, row_valid held high -> with macro, 8 consecutive shift cycles with no gap; without macro, exactly one shift=0 cycle between rows.
REQ-037 Reset mid-drain after 2 elements -> outputs return to reset values immediately and no remaining elements are emitted.
REQ-038 Round-trip: serializer feeding the team's shift-in output FIFO with random rows -> FIFO output equals row_in after each shift_last.
